// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: generates the PWM enable tick from a free-running prescaler
// and ramps the PWM duty value toward a loaded target. The ramp either fades
// to a level and holds there, or breathes as a triangle between 0 and the target.
module pwm_duty_ramp #(
  parameter int PRESCALE   = 3921,
  parameter int STEP_TICKS = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_target,
  input  logic [3:0] i_step,
  input  logic       i_mode,
  input  logic       i_load,
  output logic       o_en,
  output logic [7:0] o_duty,
  output logic       o_busy,
  output logic       o_done
);

  // Counter widths. A width of 1 is kept for degenerate parameter values.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  // Registered state
  logic [PW-1:0] r_pre_cnt;
  logic          r_en;
  logic [TW-1:0] r_tick_cnt;
  state_t        r_state;
  logic [7:0]    r_duty;
  logic          r_busy;
  logic          r_done;
  logic [7:0]    r_tgt;
  logic [3:0]    r_step;
  logic          r_mode;

  // Combinational helpers
  logic          w_step_evt;
  logic [3:0]    w_step_eff;
  logic [8:0]    w_sum9;
  logic [8:0]    w_diff9;
  logic [7:0]    w_floor;
  logic          w_up_reach;
  logic          w_dn_reach;

  // Next-state values
  state_t        w_state_nxt;
  logic [7:0]    w_duty_nxt;
  logic          w_done_nxt;
  logic [7:0]    w_tgt_nxt;
  logic [3:0]    w_step_nxt;
  logic          w_mode_nxt;

  // Free-running prescaler; en is the registered terminal-count flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre_cnt <= {PW{1'b0}};
      r_en      <= 1'b0;
    end else begin
      if (r_pre_cnt == PRE_LAST) begin
        r_pre_cnt <= {PW{1'b0}};
      end else begin
        r_pre_cnt <= r_pre_cnt + PW'(1);
      end
      r_en <= (r_pre_cnt == PRE_LAST);
    end
  end

  // Step timer counts en pulses; it is never restarted by load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick_cnt <= {TW{1'b0}};
    end else if (r_en) begin
      if (r_tick_cnt == TICK_LAST) begin
        r_tick_cnt <= {TW{1'b0}};
      end else begin
        r_tick_cnt <= r_tick_cnt + TW'(1);
      end
    end else begin
      r_tick_cnt <= r_tick_cnt;
    end
  end

  assign w_step_evt = r_en && (r_tick_cnt == TICK_LAST);
  assign w_step_eff = (i_step == 4'd0) ? 4'd1 : i_step;

  // Ramp arithmetic is done one bit wider so overshoot/undershoot is visible.
  assign w_sum9     = {1'b0, r_duty} + {5'd0, r_step};
  assign w_diff9    = {1'b0, r_duty} - {5'd0, r_step};
  assign w_floor    = r_mode ? 8'd0 : r_tgt;
  assign w_up_reach = (w_sum9 >= {1'b0, r_tgt});
  assign w_dn_reach = w_diff9[8] || (w_diff9[7:0] <= w_floor);

  // Next-state logic: load has priority over any step event.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_done_nxt  = 1'b0;
    w_tgt_nxt   = r_tgt;
    w_step_nxt  = r_step;
    w_mode_nxt  = r_mode;

    if (i_load) begin
      w_tgt_nxt  = i_target;
      w_step_nxt = w_step_eff;
      w_mode_nxt = i_mode;
      if (i_target > r_duty) begin
        w_state_nxt = ST_UP;
      end else if (i_target < r_duty) begin
        w_state_nxt = ST_DOWN;
      end else if (!i_mode) begin
        w_state_nxt = ST_HOLD;
        w_done_nxt  = 1'b1;
      end else if (i_target == 8'd0) begin
        // Breathing between 0 and 0 has nothing to do.
        w_state_nxt = ST_HOLD;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = ST_DOWN;
      end
    end else begin
      case (r_state)
        ST_UP: begin
          if (w_step_evt) begin
            if (w_up_reach) begin
              w_duty_nxt = r_tgt;
              if (r_mode) begin
                w_state_nxt = ST_DOWN;
              end else begin
                w_state_nxt = ST_HOLD;
                w_done_nxt  = 1'b1;
              end
            end else begin
              w_duty_nxt = w_sum9[7:0];
            end
          end else begin
            w_duty_nxt = r_duty;
          end
        end
        ST_DOWN: begin
          if (w_step_evt) begin
            if (w_dn_reach) begin
              w_duty_nxt = w_floor;
              if (r_mode) begin
                w_state_nxt = ST_UP;
              end else begin
                w_state_nxt = ST_HOLD;
                w_done_nxt  = 1'b1;
              end
            end else begin
              w_duty_nxt = w_diff9[7:0];
            end
          end else begin
            w_duty_nxt = r_duty;
          end
        end
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_HOLD: begin
          w_state_nxt = ST_HOLD;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_duty_nxt  = 8'd0;
        end
      endcase
    end
  end

  // State, duty and status registers; busy follows the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_duty  <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_tgt   <= 8'd0;
      r_step  <= 4'd1;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_busy  <= (w_state_nxt == ST_UP) || (w_state_nxt == ST_DOWN);
      r_done  <= w_done_nxt;
      r_tgt   <= w_tgt_nxt;
      r_step  <= w_step_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  assign o_en   = r_en;
  assign o_duty = r_duty;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Upstream companion to the 8-bit PWM stage. It generates the PWM's `en` tick from the system clock with a programmable prescaler. It also drives the PWM's 8-bit duty input, ramping it toward a loaded target in fixed steps, once per step interval. Two modes are supported: ramp-and-hold (fade to a level) and breathe (continuous triangle between 0 and the target).

## Interface
- `PRESCALE`, default 3921: clocks per `en` tick; must be ≥ 2.
- `STEP_TICKS`, default 256: `en` ticks between duty updates (256 = one PWM period); must be ≥ 1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `target`  in  8  requested duty endpoint; sampled only on `load`.
- `step`  in  4  duty increment per update; sampled on `load`; 0 is treated as 1.
- `mode`  in  1  sampled on `load`: 0 = ramp to target and hold, 1 = breathe.
- `load`  in  1  one-cycle strobe; captures `target`, `step` and `mode`, then starts a ramp.
- `en`  out  1  registered tick to the PWM; high for exactly one clk every `PRESCALE` clks.
- `duty`  out  8  registered duty value to the PWM `in` port.
- `busy`  out  1  high while in UP or DOWN.
- `done`  out  1  one-cycle pulse when a mode-0 ramp reaches its target.

## Operation
- **Prescaler.**
  - `pre_cnt` counts 0..PRESCALE-1 and wraps.
  - `en <= (pre_cnt == PRESCALE-1)`.
  - Free-running from reset; never affected by `load`.
- **Step timer.**
  - `tick_cnt` counts `en` pulses 0..STEP_TICKS-1 and wraps.
  - `step_evt = en && tick_cnt == STEP_TICKS-1`.
  - Free-running; not reset by `load`.
- **States.**
  - IDLE: post-reset, `duty` = 0.
  - UP and DOWN: ramping.
  - HOLD: `duty` frozen.
- **`load`, accepted in any state.**
  - Latches `tgt_q`, `step_q` (0→1) and `mode_q`.
  - Ramping starts from the current `duty`; `duty` does not jump.
  - Next state by comparison: `tgt_q > duty` → UP; `tgt_q < duty` → DOWN.
  - `tgt_q == duty`: mode 0 → HOLD with a `done` pulse; mode 1 → DOWN, or HOLD with `done` if both are 0.
- **UP, on `step_evt`.**
  - `duty <= min(duty + step_q, tgt_q)`, computed 9 bits wide.
  - On reaching `tgt_q`: mode 0 → HOLD with `done`; mode 1 → DOWN.
- **DOWN, on `step_evt`.**
  - Floor is `tgt_q` in mode 0 and 0 in mode 1.
  - `duty <= max(duty - step_q, floor)`, computed 9-bit signed; the result never wraps below 0.
  - On reaching the floor: mode 0 → HOLD with `done`; mode 1 → UP.
- **HOLD and IDLE.** `duty` is constant; only `load` leaves these states.
- **Mode 1 has no `done`.** `done` never pulses and `busy` stays 1 until the next `load` or reset.
- **`load` coincident with `step_evt`.** `load` wins; no step is applied on that event.
- **`busy`.** Equals (state == UP || state == DOWN), registered with the state.

## Timing
- **Reset values.** `en`=0, `duty`=0, `busy`=0, `done`=0, state IDLE. `pre_cnt`, `tick_cnt` and `tgt_q` are 0; `step_q`=1; `mode_q`=0.
- **Reset timing.** Outputs clear immediately on `rst` assertion, without a clock edge.
- **`en` cadence.** First `en` is high in the cycle after the PRESCALE-th rising edge following reset release. After that, `en` is high one cycle in every PRESCALE.
- **Duty update.** `duty` changes on the edge that samples `step_evt`, so the PWM sees the new value on the next `en`.
- **`done` alignment.** `done` is high in the same cycle the final `duty` value first appears.
- **`load` latency.** `busy` and the new state are visible 1 cycle after the `load` edge. The first step waits for the next `step_evt`.
- **Reset mid-ramp.** The ramp is abandoned; the block returns to IDLE with `duty` = 0.

## Test plan
1. PRESCALE=4, STEP_TICKS=2, release `rst` → all outputs 0. `en` pulses every 4 clks, first after the 4th edge; `step_evt` every 8 clks.
2. From IDLE, `load` target=10, step=4, mode=0 → `busy`=1; `duty` 4, 8, 10 on consecutive `step_evt`s. `done` pulses with 10; `busy` drops; `duty` holds at 10.
3. From `duty`=10, `load` target=3, step=4, mode=0 → `duty` 6, then 3 (saturated at the floor); `done`; HOLD.
4. From `duty`=0, `load` target=8, step=3, mode=1 → `duty` 3, 6, 8, 5, 2, 0, 3, … with `busy` held at 1 and `done` never asserted.
5. `load` with step=0 → increments of 1. `load` with target equal to `duty` in mode 0 → `done` 1 cycle later, `duty` unchanged, `busy`=0.
6. Assert `rst` asynchronously mid-ramp → outputs 0 before the next edge.
7. `load` coincident with `step_evt` → no `duty` change on that event.
